// File: rtl/operation_r_bw16_pkg.sv
// -----------------------------------------------------------------------------
// operation_r_bw16_pkg
// Shared definitions for the primitive-recursion operator stage:
//   - OPR_BW        : data / counter width in bits
//   - state_t       : FSM state encoding (IDLE=0 .. FINISH=4)
//   - OP_I_LATENCY  : cycles an operation_i h-unit holds its RD low
// -----------------------------------------------------------------------------
package operation_r_bw16_pkg;

    localparam int OPR_BW       = 16;
    localparam int OP_I_LATENCY = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } state_t;

endpackage

// File: rtl/operation_r_bw16_st_edge_detect.sv
// -----------------------------------------------------------------------------
// st_edge_detect
// Rising-edge detector for the ST start input of operation_* blocks.
// Ports:
//   CLK   in  clock
//   RST   in  asynchronous active-high reset
//   ST    in  start level
//   START out high during the cycle in which ST is 1 and was 0 at the last edge
// -----------------------------------------------------------------------------
module st_edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic ST,
    output logic START
);

    logic st_old_r;

    // Remember the ST level seen at the previous edge; tracks ST in every state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_old_r <= 1'b0;
        end else begin
            st_old_r <= ST;
        end
    end

    // A held-high ST yields a single START cycle only.
    assign START = ST & ~st_old_r;

endmodule

// File: rtl/operation_r_bw16.sv
// -----------------------------------------------------------------------------
// operation_r_bw16
// Primitive-recursion operator: f(0,x)=x, f(n+1,x)=h(n, f(n,x), x), where h is
// an external sub-operator driven through the SUB_* handshake.
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   ST               start (rising edge launches a run)
//   RD               ready: 0 while busy, 1 when idle / result valid
//   RES              result f(IN0, IN1), valid while RD=1
//   IN0, IN1         recursion count n and base argument x (sampled at start)
//   SUB_ST           one-cycle start pulse to the h-unit
//   SUB_RD, SUB_RES  ready / result from the h-unit
//   SUB_IN0/1/2      index i, accumulator f(i,x), base x to the h-unit
// -----------------------------------------------------------------------------
module operation_r_bw16
    import operation_r_bw16_pkg::*;
#(
    parameter int BW = OPR_BW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ST,
    output logic          RD,
    output logic [BW-1:0] RES,
    input  logic [BW-1:0] IN0,
    input  logic [BW-1:0] IN1,
    output logic          SUB_ST,
    input  logic          SUB_RD,
    input  logic [BW-1:0] SUB_RES,
    output logic [BW-1:0] SUB_IN0,
    output logic [BW-1:0] SUB_IN1,
    output logic [BW-1:0] SUB_IN2
);

    localparam logic [BW-1:0] ZERO_C = {BW{1'b0}};
    localparam logic [BW-1:0] ONE_C  = {{(BW-1){1'b0}}, 1'b1};

    state_t        state_r,   state_s;
    logic [BW-1:0] n_r,       n_s;
    logic [BW-1:0] x_r,       x_s;
    logic [BW-1:0] acc_r,     acc_s;
    logic [BW-1:0] i_r,       i_s;
    logic          rd_r,      rd_s;
    logic [BW-1:0] res_r,     res_s;
    logic          sub_st_r,  sub_st_s;
    logic [BW-1:0] sub_in0_r, sub_in0_s;
    logic [BW-1:0] sub_in1_r, sub_in1_s;
    logic [BW-1:0] sub_in2_r, sub_in2_s;
    logic [BW-1:0] i_inc_s;
    logic          start_s;

    st_edge_detect u_st_edge (
        .CLK   (CLK),
        .RST   (RST),
        .ST    (ST),
        .START (start_s)
    );

    // i never wraps: the run ends when i+1 reaches n, so n = 2^BW-1 is legal.
    assign i_inc_s = i_r + ONE_C;

    // Next-state and next-register logic for the recursion FSM.
    always_comb begin
        state_s   = state_r;
        n_s       = n_r;
        x_s       = x_r;
        acc_s     = acc_r;
        i_s       = i_r;
        rd_s      = rd_r;
        res_s     = res_r;
        sub_st_s  = 1'b0;
        sub_in0_s = sub_in0_r;
        sub_in1_s = sub_in1_r;
        sub_in2_s = sub_in2_r;

        case (state_r)
            IDLE: begin
                if (start_s) begin
                    n_s   = IN0;
                    x_s   = IN1;
                    acc_s = IN1;
                    i_s   = ZERO_C;
                    rd_s  = 1'b0;
                    if (IN0 == ZERO_C) begin
                        state_s = FINISH;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                sub_in0_s = i_r;
                sub_in1_s = acc_r;
                sub_in2_s = x_r;
                sub_st_s  = 1'b1;
                state_s   = WAIT_ACK;
            end
            WAIT_ACK: begin
                // The h-unit may still show RD=1 on the edge that sees its ST;
                // wait for it to go busy before looking for completion.
                if (!SUB_RD) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (SUB_RD) begin
                    acc_s = SUB_RES;
                    i_s   = i_inc_s;
                    if (i_inc_s == n_r) begin
                        state_s = FINISH;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            FINISH: begin
                res_s   = acc_r;
                rd_s    = 1'b1;
                state_s = IDLE;
            end
            default: begin
                rd_s    = 1'b1;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run without keeping data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= IDLE;
            n_r       <= ZERO_C;
            x_r       <= ZERO_C;
            acc_r     <= ZERO_C;
            i_r       <= ZERO_C;
            rd_r      <= 1'b1;
            res_r     <= ZERO_C;
            sub_st_r  <= 1'b0;
            sub_in0_r <= ZERO_C;
            sub_in1_r <= ZERO_C;
            sub_in2_r <= ZERO_C;
        end else begin
            state_r   <= state_s;
            n_r       <= n_s;
            x_r       <= x_s;
            acc_r     <= acc_s;
            i_r       <= i_s;
            rd_r      <= rd_s;
            res_r     <= res_s;
            sub_st_r  <= sub_st_s;
            sub_in0_r <= sub_in0_s;
            sub_in1_r <= sub_in1_s;
            sub_in2_r <= sub_in2_s;
        end
    end

    assign RD      = rd_r;
    assign RES     = res_r;
    assign SUB_ST  = sub_st_r;
    assign SUB_IN0 = sub_in0_r;
    assign SUB_IN1 = sub_in1_r;
    assign SUB_IN2 = sub_in2_r;

endmodule

// File: tb/tb_operation_r_bw16.sv
// -----------------------------------------------------------------------------
// tb_operation_r_bw16
// Directed bench for operation_r_bw16 with a behavioural h-unit whose function
// (select i, select acc, successor of acc) and busy time are set per run.
// -----------------------------------------------------------------------------
module tb_operation_r_bw16;
    import operation_r_bw16_pkg::*;

    localparam int H_SEL0 = 0;  // h returns i
    localparam int H_SEL1 = 1;  // h returns acc
    localparam int H_SUCC = 2;  // h returns acc+1

    logic        CLK;
    logic        RST;
    logic        ST;
    logic        RD;
    logic [15:0] RES;
    logic [15:0] IN0;
    logic [15:0] IN1;
    logic        SUB_ST;
    logic        SUB_RD;
    logic [15:0] SUB_RES;
    logic [15:0] SUB_IN0;
    logic [15:0] SUB_IN1;
    logic [15:0] SUB_IN2;

    int checks = 0;
    int errors = 0;

    // h-unit configuration and monitor model state
    int          hmode = H_SEL1;
    int          hlat  = 2;
    logic [15:0] cur_x = 16'h0000;
    logic [15:0] mon_acc = 16'h0000;
    int          exp_idx = 0;
    int          sub_st_count = 0;
    logic        prev_sub_st = 1'b0;
    logic [15:0] exp_res = 16'h0000;
    bit          exp_valid = 1'b0;

    operation_r_bw16 dut (
        .CLK     (CLK),
        .RST     (RST),
        .ST      (ST),
        .RD      (RD),
        .RES     (RES),
        .IN0     (IN0),
        .IN1     (IN1),
        .SUB_ST  (SUB_ST),
        .SUB_RD  (SUB_RD),
        .SUB_RES (SUB_RES),
        .SUB_IN0 (SUB_IN0),
        .SUB_IN1 (SUB_IN1),
        .SUB_IN2 (SUB_IN2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] hfun(input int mode, input logic [15:0] i,
                                         input logic [15:0] acc, input logic [15:0] x);
        case (mode)
            H_SEL0:  return i;
            H_SEL1:  return acc;
            H_SUCC:  return acc + 16'd1;
            default: return x;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural h-unit: RD drops on the edge that sees ST rise, stays low hlat cycles.
    logic        h_old;
    logic [15:0] h_pend;
    int          h_cnt;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            SUB_RD  <= 1'b1;
            SUB_RES <= 16'h0000;
            h_old   <= 1'b0;
            h_pend  <= 16'h0000;
            h_cnt   <= 0;
        end else begin
            h_old <= SUB_ST;
            if (SUB_ST && !h_old) begin
                SUB_RD <= 1'b0;
                h_pend <= hfun(hmode, SUB_IN0, SUB_IN1, SUB_IN2);
                h_cnt  <= hlat - 1;
            end else if (!SUB_RD) begin
                if (h_cnt == 0) begin
                    SUB_RD  <= 1'b1;
                    SUB_RES <= h_pend;
                end else begin
                    h_cnt <= h_cnt - 1;
                end
            end
        end
    end

    // Per-cycle compare: held result, SUB_ST pulse width and issued operands.
    always @(negedge CLK) begin
        if (!RST) begin
            if (exp_valid) check("res_hold", 32'(RES), 32'(exp_res));
            if (SUB_ST) begin
                check("sub_st_width", 32'(prev_sub_st), 32'd0);
                check("sub_in0", 32'(SUB_IN0), 32'(exp_idx));
                check("sub_in1", 32'(SUB_IN1), 32'(mon_acc));
                check("sub_in2", 32'(SUB_IN2), 32'(cur_x));
                mon_acc = hfun(hmode, exp_idx[15:0], mon_acc, cur_x);
                exp_idx++;
                sub_st_count++;
            end
            prev_sub_st = SUB_ST;
        end else begin
            prev_sub_st = 1'b0;
        end
    end

    // One run; poke_at>0 raises ST again at that edge (mid-run, then held high).
    task automatic run(input logic [15:0] n, input logic [15:0] x, input int mode,
                       input int lat, input logic [15:0] lit_res, input int lit_edges,
                       input int poke_at);
        logic [15:0] m_acc;
        int          m_edges;
        int          edges;
        m_acc = x;
        for (int k = 0; k < int'(n); k++) m_acc = hfun(mode, k[15:0], m_acc, x);
        m_edges = (n == 16'd0) ? 2 : 2 + int'(n) * (3 + lat);

        @(negedge CLK);
        hmode = mode; hlat = lat; cur_x = x; mon_acc = x;
        exp_idx = 0; sub_st_count = 0;
        IN0 = n; IN1 = x; ST = 1'b1;
        edges = 0;
        do begin
            @(posedge CLK); #1;
            edges++;
            if (edges == 1) begin
                check("rd_busy", 32'(RD), 32'd0);
                ST = 1'b0; IN0 = ~n; IN1 = ~x;
            end
            if (edges == poke_at) begin
                ST = 1'b1; IN0 = 16'd1; IN1 = 16'h0000;
            end
        end while (!RD && edges < 2000);

        check("latency_model", 32'(edges), 32'(m_edges));
        check("latency_lit", 32'(edges), 32'(lit_edges));
        check("res_model", 32'(RES), 32'(m_acc));
        check("res_lit", 32'(RES), 32'(lit_res));
        check("sub_st_count", 32'(sub_st_count), 32'(n));
        exp_res = m_acc; exp_valid = 1'b1;

        repeat (4) @(posedge CLK);
        #1;
        check("no_restart_rd", 32'(RD), 32'd1);
        check("no_restart_sub_st", 32'(sub_st_count), 32'(n));
        ST = 1'b0;
        repeat (2) @(posedge CLK);
    endtask

    initial begin
        RST = 1'b1; ST = 1'b0; IN0 = 16'h0000; IN1 = 16'h0000;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_rd", 32'(RD), 32'd1);
        check("rst_res", 32'(RES), 32'd0);
        check("rst_sub_st", 32'(SUB_ST), 32'd0);
        check("rst_sub_in", 32'({SUB_IN0, SUB_IN1} | {16'h0000, SUB_IN2}), 32'd0);
        @(negedge CLK);
        RST = 1'b0; exp_res = 16'h0000; exp_valid = 1'b1;

        run(16'd5, 16'h1234, H_SEL1, OP_I_LATENCY, 16'h1234, 27, 0);
        run(16'd7, 16'd9,    H_SEL0, OP_I_LATENCY, 16'h0006, 37, 0);
        run(16'd3, 16'hFFFE, H_SUCC, 1,            16'h0001, 14, 0);
        run(16'd0, 16'hABCD, H_SEL1, OP_I_LATENCY, 16'hABCD, 2,  0);
        run(16'd4, 16'h0010, H_SUCC, OP_I_LATENCY, 16'h0014, 22, 6);

        // Reset while the block waits for the h-unit result.
        @(negedge CLK);
        hmode = H_SEL1; hlat = 2; cur_x = 16'h0100; mon_acc = 16'h0100;
        exp_idx = 0; sub_st_count = 0;
        IN0 = 16'd3; IN1 = 16'h0100; ST = 1'b1;
        @(posedge CLK); #1;
        ST = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("arst_rd", 32'(RD), 32'd1);
        check("arst_sub_st", 32'(SUB_ST), 32'd0);
        check("arst_res", 32'(RES), 32'd0);
        check("arst_sub_in1", 32'(SUB_IN1), 32'd0);
        check("arst_sub_in2", 32'(SUB_IN2), 32'd0);
        exp_res = 16'h0000;
        @(negedge CLK);
        RST = 1'b0;

        run(16'd2, 16'h7000, H_SUCC, 3,            16'h7002, 14, 0);
        run(16'd1, 16'h0042, H_SEL0, OP_I_LATENCY, 16'h0000, 7,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
